// File: rtl/clock_gate_ctrl.sv
// Idle-detect / wake-up controller for one clock-gated domain.
// Drops the gating-cell enable after a programmable idle run and restores it on demand.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cg_enable_i,
  input  logic             busy_i,
  input  logic             req_i,
  output logic             ready_o,
  output logic             clk_en_o,
  output logic             gated_o,
  output logic [CNT_W-1:0] gate_count_o
);

  localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CNT_W-1:0] GC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GC_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_GATED     = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          gate_inc_s;
  logic          idle_s;

  assign idle_s = ~busy_i & ~req_i & cg_enable_i;

  // Next-state and countdown logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    gate_inc_s = 1'b0;
    case (state_r)
      ST_ACTIVE: begin
        if (idle_s) begin
          state_s = ST_IDLE_WAIT;
          cnt_s   = IDLE_LOAD;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_IDLE_WAIT: begin
        // Activity beats an expiring countdown on the same edge.
        if (!idle_s) begin
          state_s = ST_ACTIVE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_s    = ST_GATED;
          gate_inc_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GATED: begin
        if (req_i || !cg_enable_i) begin
          state_s = ST_WAKE;
          cnt_s   = WAKE_LOAD;
        end else begin
          state_s = ST_GATED;
        end
      end
      ST_WAKE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_ACTIVE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_ACTIVE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and countdown registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_ACTIVE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Outputs are flops decoded from the current state, so the gating-cell enable never glitches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_en_o <= 1'b1;
      ready_o  <= 1'b1;
      gated_o  <= 1'b0;
    end else begin
      clk_en_o <= (state_r != ST_GATED);
      ready_o  <= (state_r == ST_ACTIVE) || (state_r == ST_IDLE_WAIT);
      gated_o  <= (state_r == ST_GATED);
    end
  end

  // Saturating count of GATED entries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_count_o <= '0;
    end else if (gate_inc_s && (gate_count_o != GC_MAX)) begin
      gate_count_o <= gate_count_o + GC_ONE;
    end else begin
      gate_count_o <= gate_count_o;
    end
  end

endmodule
